m_bpred_btb: RTL and testbench

- Parametrised branch predictor: branch target buffer (BTB) plus a 2-bit saturating direction counter per entry.
- Successor to the pipeline's fixed "predict not-taken, flush on Ex_taken" policy.
- Looked up combinationally in IF with the fetch PC; trained from the Ex stage with each resolved conditional branch.
- Keeps saturating statistics counters for branch count and mispredict count.

---
 rtl/m_bpred_btb.sv | 114 +++++++++++
 tb/tb_m_bpred_btb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_bpred_btb.sv
// Branch target buffer with a 2-bit saturating direction counter per entry.
// Combinational IF lookup, Ex-stage training, and saturating branch/mispredict statistics.
module m_bpred_btb #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 8,
  parameter int STAT_W  = 32
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ce,
  input  logic [31:0]       w_if_pc,
  output logic              w_pred_taken,
  output logic [31:0]       w_pred_tpc,
  input  logic              w_upd_en,
  input  logic [31:0]       w_upd_pc,
  input  logic              w_upd_taken,
  input  logic [31:0]       w_upd_tpc,
  input  logic              w_upd_pred,
  output logic [STAT_W-1:0] w_nbr,
  output logic [STAT_W-1:0] w_nmiss
);

  localparam logic [1:0] CTR_WEAK_T = 2'b10;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_arr [ENTRIES];
  logic [31:0]        tgt_arr [ENTRIES];
  logic [1:0]         ctr_arr [ENTRIES];

  logic [STAT_W-1:0]  nbr;
  logic [STAT_W-1:0]  nmiss;

  logic [IDX_W-1:0]   if_idx;
  logic [TAG_W-1:0]   if_tag;
  logic               if_hit;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               upd_fire;
  logic               upd_miss;
  logic               unused_pc;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Field extraction: word-aligned index, tag above it; pc[1:0] and high bits are ignored
  assign if_idx    = w_if_pc[IDX_W+1:2];
  assign if_tag    = w_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx   = w_upd_pc[IDX_W+1:2];
  assign upd_tag   = w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{w_if_pc, w_upd_pc};

  assign if_hit  = valid[if_idx] && (tag_arr[if_idx] == if_tag);
  assign upd_hit = valid[upd_idx] && (tag_arr[upd_idx] == upd_tag);

  // Lookup reads pre-update contents; a same-cycle write shows up after the edge
  assign w_pred_taken = if_hit & ctr_arr[if_idx][1];
  assign w_pred_tpc   = w_pred_taken ? tgt_arr[if_idx] : w_if_pc + 32'd4;

  assign upd_fire = w_ce & w_upd_en;
  assign upd_miss = upd_fire & ~upd_hit & w_upd_taken;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      valid <= '0;
    end else if (upd_miss) begin
      valid[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays are never reset; a cleared valid bit makes stale contents unreachable
  always_ff @(posedge w_clk) begin
    if (upd_fire) begin
      if (upd_hit) begin
        if (w_upd_taken) begin
          ctr_arr[upd_idx] <= ctr_inc(ctr_arr[upd_idx]);
          tgt_arr[upd_idx] <= w_upd_tpc;
        end else begin
          ctr_arr[upd_idx] <= ctr_dec(ctr_arr[upd_idx]);
        end
      end else if (w_upd_taken) begin
        tag_arr[upd_idx] <= upd_tag;
        tgt_arr[upd_idx] <= w_upd_tpc;
        ctr_arr[upd_idx] <= CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      nbr   <= '0;
      nmiss <= '0;
    end else if (upd_fire) begin
      nbr <= stat_inc(nbr);
      if (w_upd_pred != w_upd_taken) begin
        nmiss <= stat_inc(nmiss);
      end
    end
  end

  assign w_nbr   = nbr;
  assign w_nmiss = nmiss;

endmodule

// File: tb/tb_m_bpred_btb.sv
// Scoreboard bench for m_bpred_btb: an associative-array reference model predicts each cycle's
// lookup and statistics; a negedge monitor pops and compares against two DUTs (STAT_W 32 and 3).
module tb_m_bpred_btb;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 8;

  logic        w_clk;
  logic        w_rst;
  logic        w_ce;
  logic [31:0] w_if_pc;
  logic        w_upd_en;
  logic [31:0] w_upd_pc;
  logic        w_upd_taken;
  logic [31:0] w_upd_tpc;
  logic        w_upd_pred;

  logic        w_pred_taken;
  logic [31:0] w_pred_tpc;
  logic [31:0] w_nbr;
  logic [31:0] w_nmiss;
  logic        w_pred_taken3;
  logic [31:0] w_pred_tpc3;
  logic [2:0]  w_nbr3;
  logic [2:0]  w_nmiss3;

  m_bpred_btb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .STAT_W(32)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_ce(w_ce), .w_if_pc(w_if_pc),
    .w_pred_taken(w_pred_taken), .w_pred_tpc(w_pred_tpc),
    .w_upd_en(w_upd_en), .w_upd_pc(w_upd_pc), .w_upd_taken(w_upd_taken),
    .w_upd_tpc(w_upd_tpc), .w_upd_pred(w_upd_pred),
    .w_nbr(w_nbr), .w_nmiss(w_nmiss)
  );

  m_bpred_btb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .STAT_W(3)) dut3 (
    .w_clk(w_clk), .w_rst(w_rst), .w_ce(w_ce), .w_if_pc(w_if_pc),
    .w_pred_taken(w_pred_taken3), .w_pred_tpc(w_pred_tpc3),
    .w_upd_en(w_upd_en), .w_upd_pc(w_upd_pc), .w_upd_taken(w_upd_taken),
    .w_upd_tpc(w_upd_tpc), .w_upd_pred(w_upd_pred),
    .w_nbr(w_nbr3), .w_nmiss(w_nmiss3)
  );

  // Reference model: one entry per occupied index, keyed by index
  typedef struct {
    longint unsigned tag;
    logic [31:0]     tgt;
    int              ctr;
  } ent_t;

  typedef struct {
    logic [31:0] if_pc;
    logic        taken;
    logic [31:0] tpc;
    longint      nbr;
    longint      nmiss;
  } exp_t;

  ent_t   mdl [int];
  longint m_nbr;
  longint m_nmiss;
  exp_t   sb_q [$];

  int tests = 0;
  int fails = 0;

  initial w_clk = 1'b1;
  always #5 w_clk = ~w_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(input logic [31:0] pc);
    return longint'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return mdl.exists(idx_of(pc)) && (mdl[idx_of(pc)].tag == tag_of(pc));
  endfunction

  function automatic void model_reset();
    mdl.delete();
    m_nbr   = 0;
    m_nmiss = 0;
  endfunction

  function automatic void push_expect();
    exp_t e;
    logic [31:0] nxt;
    nxt     = w_if_pc + 32'd4;
    e.if_pc = w_if_pc;
    e.taken = m_hit(w_if_pc) && (mdl[idx_of(w_if_pc)].ctr >= 2);
    e.tpc   = e.taken ? mdl[idx_of(w_if_pc)].tgt : nxt;
    e.nbr   = m_nbr;
    e.nmiss = m_nmiss;
    sb_q.push_back(e);
  endfunction

  // Applied at the active edge with the inputs that the DUT sees on that edge
  function automatic void model_update();
    int   i;
    ent_t n;
    if (w_rst || !w_ce || !w_upd_en) return;
    i = idx_of(w_upd_pc);
    if (m_hit(w_upd_pc)) begin
      if (w_upd_taken) begin
        mdl[i].ctr = (mdl[i].ctr + 1 > 3) ? 3 : mdl[i].ctr + 1;
        mdl[i].tgt = w_upd_tpc;
      end else begin
        mdl[i].ctr = (mdl[i].ctr - 1 < 0) ? 0 : mdl[i].ctr - 1;
      end
    end else if (w_upd_taken) begin
      n.tag  = tag_of(w_upd_pc);
      n.tgt  = w_upd_tpc;
      n.ctr  = 2;
      mdl[i] = n;
    end
    m_nbr++;
    if (w_upd_pred != w_upd_taken) m_nmiss++;
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] pc,
                              input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (if_pc=%08h): got %0h, expected %0h", name, pc, act, exp);
    end
  endfunction

  // Monitor: the lookup is combinational, so the DUT presents a result every cycle
  always @(negedge w_clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pred_taken", e.if_pc, longint'(w_pred_taken), longint'(e.taken));
      chk("pred_tpc",   e.if_pc, longint'(w_pred_tpc),   longint'(e.tpc));
      chk("nbr",        e.if_pc, longint'(w_nbr),        sat(e.nbr, 64'hFFFF_FFFF));
      chk("nmiss",      e.if_pc, longint'(w_nmiss),      sat(e.nmiss, 64'hFFFF_FFFF));
      chk("pred_taken_s3", e.if_pc, longint'(w_pred_taken3), longint'(e.taken));
      chk("pred_tpc_s3",   e.if_pc, longint'(w_pred_tpc3),   longint'(e.tpc));
      chk("nbr_s3",        e.if_pc, longint'(w_nbr3),        sat(e.nbr, 7));
      chk("nmiss_s3",      e.if_pc, longint'(w_nmiss3),      sat(e.nmiss, 7));
    end
  end

  // One cycle: drive, record expectation, then let the model follow the edge
  task automatic step(input logic ce, input logic en, input logic [31:0] upc,
                      input logic tk, input logic [31:0] tpc, input logic pred,
                      input logic [31:0] ifpc);
    w_ce        = ce;
    w_upd_en    = en;
    w_upd_pc    = upc;
    w_upd_taken = tk;
    w_upd_tpc   = tpc;
    w_upd_pred  = pred;
    w_if_pc     = ifpc;
    push_expect();
    @(posedge w_clk);
    model_update();
    #1;
  endtask

  task automatic look(input logic [31:0] ifpc);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ifpc);
  endtask

  task automatic upd(input logic [31:0] upc, input logic tk, input logic [31:0] tpc,
                     input logic pred, input logic [31:0] ifpc);
    step(1'b1, 1'b1, upc, tk, tpc, pred, ifpc);
  endtask

  task automatic sync_reset_pulse();
    w_rst = 1'b1;
    model_reset();
    look(32'h40);
    w_rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_0000);
    return pc;
  endfunction

  initial begin
    w_rst = 1'b1;
    model_reset();
    w_ce = 1'b0; w_upd_en = 1'b0; w_upd_pc = '0; w_upd_taken = 1'b0;
    w_upd_tpc = '0; w_upd_pred = 1'b0; w_if_pc = 32'h40;

    // Reset state, including an update offered while reset is held
    look(32'h40);
    upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h40);
    w_rst = 1'b0;

    // Cold lookup and allocation
    look(32'h40);
    upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h40);
    look(32'h40);

    // Hysteresis and saturation
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h40);
    look(32'h40);
    upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h40);
    look(32'h40);
    upd(32'h40, 1'b1, 32'h10, 1'b0, 32'h40);
    look(32'h40);
    for (int k = 0; k < 3; k++) upd(32'h40, 1'b1, 32'h10, 1'b1, 32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h40);
    look(32'h40);

    // Aliasing on index 16
    look(32'h140);
    upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h140);
    look(32'h140);
    look(32'h40);
    upd(32'h240, 1'b0, 32'h0, 1'b0, 32'h140);
    look(32'h140);
    look(32'h240);

    // Statistics: five updates, two mispredicted, then a gated update
    sync_reset_pulse();
    upd(32'h80, 1'b1, 32'h100, 1'b1, 32'h80);
    upd(32'h84, 1'b0, 32'h0,   1'b1, 32'h80);
    upd(32'h88, 1'b0, 32'h0,   1'b0, 32'h80);
    upd(32'h8C, 1'b1, 32'h300, 1'b0, 32'h8C);
    upd(32'h80, 1'b1, 32'h104, 1'b1, 32'h80);
    look(32'h80);
    step(1'b0, 1'b1, 32'h90, 1'b1, 32'h500, 1'b0, 32'h90);
    look(32'h90);
    look(32'h80);

    // STAT_W=3 saturation: nine more updates push the narrow instance past 7
    for (int k = 0; k < 9; k++) upd(32'h40 + 32'(k * 4), k[0], 32'h600, 1'b0, 32'h40);
    look(32'h44);

    // Asynchronous reset mid-cycle with 0x40 predicting taken
    upd(32'h40, 1'b1, 32'h10, 1'b1, 32'h40);
    look(32'h40);
    #1;
    w_rst = 1'b1;
    model_reset();
    upd(32'h40, 1'b1, 32'h10, 1'b1, 32'h40);
    w_rst = 1'b0;
    look(32'h40);

    // PC+4 wraps at the top of the address space
    look(32'hFFFF_FFFC);

    // Randomised traffic over a small, heavily aliased PC set
    for (int n = 0; n < 600; n++) begin
      logic [31:0] upc;
      logic [31:0] ipc;
      upc = rand_pc();
      ipc = ($urandom_range(0, 1) == 0) ? upc : rand_pc();
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), upc,
           1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ipc);
    end

    @(negedge w_clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
